// File: rtl/len_to_tkeep_packetizer_pkg.sv
// Shared definitions for the length-to-TKEEP packetizer: FSM encoding,
// bus geometry helpers and the TKEEP byte-order convention.
package len_to_tkeep_packetizer_pkg;

    // TKEEP polarity: the MSB of the keep vector describes byte 0 (big-endian).
    localparam bit KEEP_MSB_IS_BYTE0 = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } pkt_state_t;

    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int lb_of(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/len_to_tkeep_packetizer_mask.sv
// Combinational count-minus-one to left-aligned TKEEP mask; the inverse of the
// TKEEP-to-length encoder. count_m1 = 0 keeps byte 0 only.
module len_to_tkeep_mask
    import len_to_tkeep_packetizer_pkg::*;
#(
    parameter int BYTES = 8,
    parameter int LB    = $clog2(BYTES)
) (
    input  logic [LB-1:0]    count_m1,
    output logic [BYTES-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (LB'(i) <= count_m1) begin
                if (KEEP_MSB_IS_BYTE0) mask[BYTES-1-i] = 1'b1;
                else                   mask[i]         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/len_to_tkeep_packetizer.sv
// Accepts a length-minus-one command, then tags the following payload beats
// with a left-aligned TKEEP and TLAST through a one-entry output register.
module len_to_tkeep_packetizer
    import len_to_tkeep_packetizer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LEN_WIDTH-1:0]      cmd_len,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready
);

    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int LB    = lb_of(DATA_WIDTH);
    localparam int BW    = LEN_WIDTH - LB;

    pkt_state_t        state;
    logic              stream_q;
    logic [BW-1:0]     beats_left;
    logic [LB-1:0]     last_bytes;
    logic [BYTES-1:0]  last_mask;
    logic              beat_accept;
    logic              final_beat;

    // Output slot is free when empty or being drained this cycle.
    assign s_tready    = stream_q && (!m_tvalid || m_tready);
    assign beat_accept = s_tvalid && s_tready;
    assign final_beat  = (beats_left == '0);

    len_to_tkeep_mask #(
        .BYTES (BYTES),
        .LB    (LB)
    ) u_mask (
        .count_m1 (last_bytes),
        .mask     (last_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            stream_q   <= 1'b0;
            beats_left <= '0;
            last_bytes <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        beats_left <= cmd_len[LEN_WIDTH-1:LB];
                        last_bytes <= cmd_len[LB-1:0];
                        state      <= ST_STREAM;
                        cmd_ready  <= 1'b0;
                        stream_q   <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (beat_accept) begin
                        if (final_beat) begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                            stream_q  <= 1'b0;
                        end else begin
                            beats_left <= beats_left - BW'(1);
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    stream_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register runs independently of the FSM so the last beat can
    // drain while the next command is being taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (beat_accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s_tdata;
            m_tkeep  <= final_beat ? last_mask : '1;
            m_tlast  <= final_beat;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_len_to_tkeep_packetizer.sv
// Directed bench for len_to_tkeep_packetizer with DATA_WIDTH=64; output beats
// are checked against a queue of hand-computed {data, keep, last} records.
module tb_len_to_tkeep_packetizer;

  localparam int DW = 64;
  localparam int LW = 16;
  localparam int KW = DW / 8;
  localparam int RW = DW + KW + 1;

  logic          clk;
  logic          rst_n;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cmd_acc_cyc;
  int beat_acc_cyc;
  int p1_cyc, cmd2_cyc, q_cyc;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] exp_rec;

  len_to_tkeep_packetizer #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_len   (cmd_len),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tlast   (m_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a handshake is seen at the negedge before the edge that takes it
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      check("beat_expected", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        exp_rec = exp_q.pop_front();
        check("m_tdata", m_tdata, exp_rec[RW-1:KW+1]);
        check("m_tkeep", m_tkeep, exp_rec[KW:1]);
        check("m_tlast", m_tlast, exp_rec[0]);
      end
    end
  end

  task automatic expect_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l);
    exp_q.push_back({d, k, l});
  endtask

  task automatic send_cmd(input logic [LW-1:0] len);
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    cmd_acc_cyc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    s_tdata  = d;
    s_tvalid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (s_tready) break;
    end
    check("beat_accept", s_tready, 1'b1);
    beat_acc_cyc = cyc;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_len   = '0;
    cmd_valid = 1'b0;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tkeep", m_tkeep, 8'h00);
    check("rst_m_tdata", m_tdata, 64'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_s_tready", s_tready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // cmd_len=0, with payload offered early in IDLE (must not be taken)
    s_tdata  = 64'hA0A1_A2A3_A4A5_A6A7;
    s_tvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_s_tready", s_tready, 1'b0);
      @(posedge clk); #1;
    end
    expect_beat(64'hA0A1_A2A3_A4A5_A6A7, 8'h80, 1'b1);
    send_cmd(16'd0);
    send_beat(64'hA0A1_A2A3_A4A5_A6A7);
    check("len0_beat_cycle", beat_acc_cyc - cmd_acc_cyc, 1);
    drain();

    // cmd_len=2: keep E0, cmd_ready back one cycle after acceptance
    expect_beat(64'h1111_2222_3333_4444, 8'hE0, 1'b1);
    send_cmd(16'd2);
    @(negedge clk);
    check("stream_cmd_ready", cmd_ready, 1'b0);
    @(posedge clk); #1;
    send_beat(64'h1111_2222_3333_4444);
    @(negedge clk);
    check("len2_cmd_ready", cmd_ready, 1'b1);
    check("len2_latency_valid", m_tvalid, 1'b1);
    check("len2_latency_keep", m_tkeep, 8'hE0);
    @(posedge clk); #1;
    drain();

    // cmd_len=15: two full beats
    expect_beat(64'h0102_0304_0506_0708, 8'hFF, 1'b0);
    expect_beat(64'h090A_0B0C_0D0E_0F10, 8'hFF, 1'b1);
    send_cmd(16'd15);
    send_beat(64'h0102_0304_0506_0708);
    send_beat(64'h090A_0B0C_0D0E_0F10);
    drain();

    // cmd_len=19 with a three-cycle stall on the second beat
    expect_beat(64'hB000_0000_0000_0001, 8'hFF, 1'b0);
    expect_beat(64'hB000_0000_0000_0002, 8'hFF, 1'b0);
    expect_beat(64'hB000_0000_0000_0003, 8'hF0, 1'b1);
    send_cmd(16'd19);
    send_beat(64'hB000_0000_0000_0001);
    send_beat(64'hB000_0000_0000_0002);
    m_tready = 1'b0;
    s_tdata  = 64'hB000_0000_0000_0003;
    s_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_s_tready", s_tready, 1'b0);
      check("stall_m_tvalid", m_tvalid, 1'b1);
      check("stall_m_tdata", m_tdata, 64'hB000_0000_0000_0002);
      check("stall_m_tlast", m_tlast, 1'b0);
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    send_beat(64'hB000_0000_0000_0003);
    drain();

    // Back-to-back packets, cmd_len=7 then 8
    expect_beat(64'hC1C1_C1C1_C1C1_C1C1, 8'hFF, 1'b1);
    expect_beat(64'hC2C2_C2C2_C2C2_C2C2, 8'hFF, 1'b0);
    expect_beat(64'hC3C3_C3C3_C3C3_C3C3, 8'h80, 1'b1);
    send_cmd(16'd7);
    send_beat(64'hC1C1_C1C1_C1C1_C1C1);
    p1_cyc = beat_acc_cyc;
    send_cmd(16'd8);
    cmd2_cyc = cmd_acc_cyc;
    send_beat(64'hC2C2_C2C2_C2C2_C2C2);
    q_cyc = beat_acc_cyc;
    send_beat(64'hC3C3_C3C3_C3C3_C3C3);
    check("b2b_cmd_gap", cmd2_cyc - p1_cyc, 1);
    check("b2b_beat_gap", q_cyc - p1_cyc, 2);
    check("b2b_no_bubble", beat_acc_cyc - q_cyc, 1);
    drain();

    // Reset mid-packet of cmd_len=23; the held beat is abandoned
    m_tready = 1'b0;
    send_cmd(16'd23);
    send_beat(64'hDEAD_BEEF_0000_0001);
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", m_tvalid, 1'b0);
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_s_tready", s_tready, 1'b0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    @(posedge clk); #1;
    expect_beat(64'h7777_6666_5555_4444, 8'hF0, 1'b1);
    send_cmd(16'd3);
    send_beat(64'h7777_6666_5555_4444);
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) $display("[TB] PASS");
    else             $display("[TB] FAIL");
    $finish;
  end

endmodule
